// File: rtl/core_types_pkg.sv
// Core-wide physical register file sizing shared by all PRF blocks.
package core_types_pkg;

    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int PRF_ENTRY_WIDTH    = 32;

endpackage

// File: rtl/prf_bank_read_responder_pkg.sv
// Helpers for the PRF bank read responder.
package prf_bank_read_responder_pkg;

    import core_types_pkg::*;

    // Bank 0 entry 0 is the architectural zero register.
    function automatic logic is_zero_entry(input logic [LOG_PRF_BANK_COUNT-1:0] bank,
                                           input logic index_is_zero);
        return (bank == '0) && index_is_zero;
    endfunction

endpackage

// File: rtl/prf_bank_read_responder_rr_arbiter.sv
// Combinational round-robin arbiter: nearest valid requester at or above ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int LOG_N = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [LOG_N-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [LOG_N-1:0] grant_index,
    output logic             grant_valid
);

    int cand;

    // Walk from the farthest candidate inward so the nearest one overrides.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= N) cand = cand - N;
            if (req[LOG_N'(cand)]) begin
                grant                   = '0;
                grant[LOG_N'(cand)]     = 1'b1;
                grant_index             = LOG_N'(cand);
                grant_valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prf_bank_read_responder_wrapper.sv
// Synthesis wrapper: flops every port around prf_bank_read_responder for timing runs.
module prf_bank_read_responder_wrapper
    import core_types_pkg::*;
#(
    parameter int REQUESTER_COUNT  = 4,
    parameter int BANK_ENTRIES     = 32,
    parameter int LOG_BANK_ENTRIES = $clog2(BANK_ENTRIES),
    parameter int BANK_INDEX       = 0
) (
    input  logic                                             CLK,
    input  logic                                             nRST,
    input  logic [REQUESTER_COUNT-1:0]                       read_req_valid_by_rq,
    input  logic [REQUESTER_COUNT-1:0][LOG_BANK_ENTRIES-1:0] read_req_index_by_rq,
    output logic [REQUESTER_COUNT-1:0]                       read_req_ack_by_rq,
    output logic [REQUESTER_COUNT-1:0]                       reg_read_resp_valid_by_rq,
    output logic [PRF_ENTRY_WIDTH-1:0]                       reg_read_resp_data,
    input  logic                                             write_valid,
    input  logic [LOG_BANK_ENTRIES-1:0]                      write_index,
    input  logic [PRF_ENTRY_WIDTH-1:0]                       write_data,
    output logic                                             bus_forward_valid,
    output logic [PRF_ENTRY_WIDTH-1:0]                       bus_forward_data
);

    logic [REQUESTER_COUNT-1:0]                       q_req_valid;
    logic [REQUESTER_COUNT-1:0][LOG_BANK_ENTRIES-1:0] q_req_index;
    logic                                             q_write_valid;
    logic [LOG_BANK_ENTRIES-1:0]                      q_write_index;
    logic [PRF_ENTRY_WIDTH-1:0]                       q_write_data;
    logic [REQUESTER_COUNT-1:0]                       core_ack;
    logic [REQUESTER_COUNT-1:0]                       core_resp_valid;
    logic [PRF_ENTRY_WIDTH-1:0]                       core_resp_data;
    logic                                             core_fwd_valid;
    logic [PRF_ENTRY_WIDTH-1:0]                       core_fwd_data;

    prf_bank_read_responder #(
        .REQUESTER_COUNT  (REQUESTER_COUNT),
        .BANK_ENTRIES     (BANK_ENTRIES),
        .LOG_BANK_ENTRIES (LOG_BANK_ENTRIES),
        .BANK_INDEX       (BANK_INDEX)
    ) u_core (
        .CLK                       (CLK),
        .nRST                      (nRST),
        .read_req_valid_by_rq      (q_req_valid),
        .read_req_index_by_rq      (q_req_index),
        .read_req_ack_by_rq        (core_ack),
        .reg_read_resp_valid_by_rq (core_resp_valid),
        .reg_read_resp_data        (core_resp_data),
        .write_valid               (q_write_valid),
        .write_index               (q_write_index),
        .write_data                (q_write_data),
        .bus_forward_valid         (core_fwd_valid),
        .bus_forward_data          (core_fwd_data)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_req_valid               <= '0;
            q_req_index               <= '0;
            q_write_valid             <= 1'b0;
            q_write_index             <= '0;
            q_write_data              <= '0;
            read_req_ack_by_rq        <= '0;
            reg_read_resp_valid_by_rq <= '0;
            reg_read_resp_data        <= '0;
            bus_forward_valid         <= 1'b0;
            bus_forward_data          <= '0;
        end else begin
            q_req_valid               <= read_req_valid_by_rq;
            q_req_index               <= read_req_index_by_rq;
            q_write_valid             <= write_valid;
            q_write_index             <= write_index;
            q_write_data              <= write_data;
            read_req_ack_by_rq        <= core_ack;
            reg_read_resp_valid_by_rq <= core_resp_valid;
            reg_read_resp_data        <= core_resp_data;
            bus_forward_valid         <= core_fwd_valid;
            bus_forward_data          <= core_fwd_data;
        end
    end

endmodule

// File: rtl/prf_bank_read_responder.sv
// One PRF bank: round-robin shared read port with write bypass and writeback echo.
module prf_bank_read_responder
    import core_types_pkg::*;
    import prf_bank_read_responder_pkg::*;
#(
    parameter int REQUESTER_COUNT  = 4,
    parameter int BANK_ENTRIES     = 32,
    parameter int LOG_BANK_ENTRIES = $clog2(BANK_ENTRIES),
    parameter int BANK_INDEX       = 0
) (
    input  logic                                             CLK,
    input  logic                                             nRST,
    input  logic [REQUESTER_COUNT-1:0]                       read_req_valid_by_rq,
    input  logic [REQUESTER_COUNT-1:0][LOG_BANK_ENTRIES-1:0] read_req_index_by_rq,
    output logic [REQUESTER_COUNT-1:0]                       read_req_ack_by_rq,
    output logic [REQUESTER_COUNT-1:0]                       reg_read_resp_valid_by_rq,
    output logic [PRF_ENTRY_WIDTH-1:0]                       reg_read_resp_data,
    input  logic                                             write_valid,
    input  logic [LOG_BANK_ENTRIES-1:0]                      write_index,
    input  logic [PRF_ENTRY_WIDTH-1:0]                       write_data,
    output logic                                             bus_forward_valid,
    output logic [PRF_ENTRY_WIDTH-1:0]                       bus_forward_data
);

    localparam int LOG_RQ = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;
    localparam logic [LOG_PRF_BANK_COUNT-1:0] BANK_ID = LOG_PRF_BANK_COUNT'(BANK_INDEX);

    logic [PRF_ENTRY_WIDTH-1:0] entries [BANK_ENTRIES];
    logic [LOG_RQ-1:0]          rr_ptr;
    logic [REQUESTER_COUNT-1:0] grant;
    logic [LOG_RQ-1:0]          grant_index;
    logic                       grant_valid;
    logic [LOG_BANK_ENTRIES-1:0] read_index;
    logic [PRF_ENTRY_WIDTH-1:0] read_data;
    logic                       write_blocked;

    rr_arbiter #(
        .N     (REQUESTER_COUNT),
        .LOG_N (LOG_RQ)
    ) u_rr_arbiter (
        .req         (read_req_valid_by_rq),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_index (grant_index),
        .grant_valid (grant_valid)
    );

    assign read_req_ack_by_rq = grant;

    // Same-cycle writeback wins over the stored entry; the zero register wins over both.
    always_comb begin
        read_index    = read_req_index_by_rq[grant_index];
        write_blocked = is_zero_entry(BANK_ID, write_index == '0);
        if (is_zero_entry(BANK_ID, read_index == '0)) begin
            read_data = '0;
        end else if (write_valid && (write_index == read_index)) begin
            read_data = write_data;
        end else begin
            read_data = entries[read_index];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr                    <= '0;
            reg_read_resp_valid_by_rq <= '0;
            reg_read_resp_data        <= '0;
        end else begin
            reg_read_resp_valid_by_rq <= grant;
            if (grant_valid) begin
                reg_read_resp_data <= read_data;
                if (grant_index == LOG_RQ'(REQUESTER_COUNT - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_index + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BANK_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (write_valid && !write_blocked) begin
            entries[write_index] <= write_data;
        end
    end

    // The echo is taken for every write, including the discarded zero-register one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus_forward_valid <= 1'b0;
            bus_forward_data  <= '0;
        end else begin
            bus_forward_valid <= write_valid;
            if (write_valid) begin
                bus_forward_data <= write_data;
            end
        end
    end

endmodule

// File: doc/prf_bank_read_responder.md
PRF_BANK_READ_RESPONDER -- requirements
Module: prf_bank_read_responder

Interface
REQ-001 SHALL have parameter REQUESTER_COUNT, default 4, number of operand-collector requesters sharing this bank read port.
REQ-002 SHALL have parameter BANK_ENTRIES, default 32, physical registers held in this bank.
REQ-003 SHALL have parameter LOG_BANK_ENTRIES, default $clog2(BANK_ENTRIES), index width.
REQ-004 SHALL have parameter BANK_INDEX, default 0, this bank's number (0..PRF_BANK_COUNT-1).
REQ-005 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port read_req_valid_by_rq  input  REQUESTER_COUNT  per-requester read request, held until acked.
REQ-008 SHALL have port read_req_index_by_rq  input  REQUESTER_COUNT x LOG_BANK_ENTRIES  per-requester entry index.
REQ-009 SHALL have port read_req_ack_by_rq  output  REQUESTER_COUNT  one-hot grant, combinational, same cycle.
REQ-010 SHALL have port reg_read_resp_valid_by_rq  output  REQUESTER_COUNT  one-hot response strobe, registered.
REQ-011 SHALL have port reg_read_resp_data  output  32  response data shared by all requesters, registered.
REQ-012 SHALL have ports write_valid  input  1; write_index  input  LOG_BANK_ENTRIES; write_data  input  32  writeback port.
REQ-013 SHALL have ports bus_forward_valid  output  1; bus_forward_data  output  32  registered echo of writeback.

Function
REQ-014 SHALL grant at most one requester per cycle; ack=0 for all when no valid request.
REQ-015 SHALL arbitrate round-robin: search from rr_ptr upward with wrap; lowest-distance valid requester wins.
REQ-016 SHALL update rr_ptr on grant to (granted+1) mod REQUESTER_COUNT; unchanged when no grant.
REQ-017 SHALL assert reg_read_resp_valid_by_rq one-hot for the granted requester exactly 1 cycle after grant; 0 otherwise.
REQ-018 SHALL drive reg_read_resp_data in the response cycle with entry[index] as of the grant cycle.
REQ-019 SHALL bypass: write_valid with write_index equal to granted index in grant cycle returns write_data.
REQ-020 SHALL update entry[write_index] <= write_data at rising edge when write_valid.
REQ-021 SHALL, when BANK_INDEX==0, read entry 0 as 32'h0 (including bypass) and ignore writes to entry 0.
REQ-022 SHALL hold reg_read_resp_data at last value when no response (don't-care for consumers, but stable).
REQ-023 SHALL assert bus_forward_valid and bus_forward_data=write_data 1 cycle after write_valid, including entry 0 writes.
REQ-024 SHALL sustain back-to-back grants every cycle with no bubble; continuous requesters each served within REQUESTER_COUNT cycles.
REQ-025 SHALL ignore index of non-valid requesters; requester dropping valid before ack is legal and loses nothing stored.

Reset
REQ-026 SHALL on nRST low immediately clear rr_ptr, all entries, reg_read_resp_valid_by_rq, reg_read_resp_data, bus_forward_valid, bus_forward_data to 0.
REQ-027 SHALL drop any response pending from a grant in the cycle reset asserts; no response after reset release without new grant.

Structure
REQ-028 SHALL take PRF_BANK_COUNT, LOG_PRF_BANK_COUNT and PRF entry sizing from core_types_pkg; no new package typedefs needed.
REQ-029 SHALL place the round-robin arbiter in one sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).
REQ-030 SHALL provide prf_bank_read_responder_wrapper with registered ports for synthesis timing, matching other block wrappers.

Verification
REQ-031 SHALL test reset: after release all outputs 0; read of every index returns 32'h0.
REQ-032 SHALL test write idx 5 = 32'hDEADBEEF, next cycle rq1 reads idx 5 -> ack1 same cycle, resp_valid=4'b0010 and data DEADBEEF one cycle later; bus_forward DEADBEEF the cycle after write.
REQ-033 SHALL test all 4 requesters valid continuously from rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-034 SHALL test same-cycle write idx 7 = 32'h12345678 and grant idx 7 -> response 32'h12345678.
REQ-035 SHALL test BANK_INDEX=0: write entry 0 = 32'hFFFFFFFF then read 0 -> 32'h0; bus_forward still shows FFFFFFFF.
REQ-036 SHALL test nRST pulse in the cycle after a grant -> no reg_read_resp_valid; rr_ptr restarts at 0.
